// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one UART frame transmitter among requesters.
// Optional FRAME_GAP_EN: inter-frame gap lasts GAP_CYC cycles instead of 1.
module uart_frame_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_W     = 40,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_vec,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         ack_vec,
  output logic [NUM_REQ-1:0]         err_vec,
  output logic                       busy,
  output logic                       tx_go,
  output logic [FRAME_W-1:0]         tx_data,
  input  logic                       tx_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_REQ - 1);

`ifdef FRAME_GAP_EN
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
`else
  // Single idle cycle; GAP_CYC only shapes the gap with the feature on.
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC * 0);
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     idx;
  logic [15:0]       cnt;
  logic              gnt_any;
  logic [IW-1:0]     gnt_idx;
  logic [IW:0]       slot;
  logic [NUM_REQ-1:0] sel_1h;

  // Walk downward so the nearest set bit at/after rr_ptr wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    slot    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_ptr} + (IW+1)'(k);
      if (slot >= (IW+1)'(NUM_REQ))
        slot = slot - (IW+1)'(NUM_REQ);
      if (req_vec[slot[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = slot[IW-1:0];
      end
    end
  end

  assign sel_1h = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      idx     <= '0;
      cnt     <= '0;
      ack_vec <= '0;
      err_vec <= '0;
      busy    <= 1'b0;
      tx_go   <= 1'b0;
      tx_data <= '0;
    end else begin
      ack_vec <= '0;
      err_vec <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            idx   <= gnt_idx;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= req_data[idx*FRAME_W +: FRAME_W];
          tx_go   <= 1'b1;
          cnt     <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (tx_done || cnt == TO_LAST) begin
            tx_go  <= 1'b0;
            cnt    <= '0;
            state  <= GAP;
            rr_ptr <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            if (tx_done) ack_vec <= sel_1h;
            else         err_vec <= sel_1h;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
